// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: screen size and the player state encoding.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_RISE,
        ST_FALL
    } player_state_t;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between the VGA drawing stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/player_ctl.sv
// Player motion: frame tick detection, jump latching, horizontal moves and
// the vertical jump state machine. Positions only move on the frame tick.
//
//   state     | meaning
//   ST_GROUND | resting on the ground line, vy = 0
//   ST_RISE   | moving up, vy decremented each tick until it reaches 0
//   ST_FALL   | moving down, vy increments up to the fall cap until landing
module player_ctl
    import vga_pkg::*;
#(
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 48,
    parameter int X_INIT   = 100,
    parameter int GROUND_Y = 500,
    parameter int SPEED_X  = 2,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        on_ground
);

    localparam logic [10:0] Y_REST = 11'(GROUND_Y - PLAYER_H);
    localparam logic [10:0] X_MAX  = 11'(HOR_PIXELS - PLAYER_W);
    localparam logic [10:0] SPD    = 11'(SPEED_X);
    localparam logic [5:0]  V0     = 6'(JUMP_V0);
    localparam logic [5:0]  GRV    = 6'(GRAVITY);
    localparam logic [5:0]  VMAX   = 6'(MAX_FALL);

    logic          vblnk_d;
    logic          tick;
    logic          jump_req;
    logic          jump_now;
    player_state_t state;
    logic [5:0]    vy;
    logic [10:0]   x_next;
    logic [11:0]   x_sum;
    logic [6:0]    vy_inc;
    logic [5:0]    vy_fall;
    logic [5:0]    vy_rise;
    logic [10:0]   y_rise;
    logic [11:0]   y_fall;

    assign tick     = vblnk & ~vblnk_d;
    // a press on the tick cycle itself must still count for that tick
    assign jump_now = jump_req | btn_jump;

    // next horizontal position; clamps are decided before any subtraction
    always_comb begin
        x_next = pos_x;
        x_sum  = {1'b0, pos_x} + {1'b0, SPD};
        if (btn_left && !btn_right) begin
            x_next = (pos_x < SPD) ? 11'd0 : pos_x - SPD;
        end else if (btn_right && !btn_left) begin
            x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[10:0];
        end
    end

    // next vertical values for the rising and falling phases
    always_comb begin
        vy_inc  = {1'b0, vy} + {1'b0, GRV};
        vy_fall = (vy_inc > {1'b0, VMAX}) ? VMAX : vy_inc[5:0];
        vy_rise = (vy < GRV) ? 6'd0 : vy - GRV;
        y_rise  = (pos_y < {5'd0, vy}) ? 11'd0 : pos_y - {5'd0, vy};
        y_fall  = {1'b0, pos_y} + {6'd0, vy_fall};
    end

    // frame tick edge detector and jump request latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_d  <= 1'b0;
            jump_req <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            if (tick) begin
                jump_req <= 1'b0;
            end else if (btn_jump) begin
                jump_req <= 1'b1;
            end
        end
    end

    // horizontal position register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x <= 11'(X_INIT);
        end else if (tick) begin
            pos_x <= x_next;
        end
    end

    // vertical jump FSM with registered position and ground flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_GROUND;
            vy        <= '0;
            pos_y     <= Y_REST;
            on_ground <= 1'b1;
        end else if (tick) begin
            case (state)
                ST_GROUND: begin
                    pos_y <= Y_REST;
                    vy    <= '0;
                    if (jump_now) begin
                        vy        <= V0;
                        state     <= ST_RISE;
                        on_ground <= 1'b0;
                    end
                end
                ST_RISE: begin
                    pos_y <= y_rise;
                    vy    <= vy_rise;
                    if (vy_rise == 6'd0) begin
                        state <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (y_fall >= {1'b0, Y_REST}) begin
                        pos_y     <= Y_REST;
                        vy        <= '0;
                        state     <= ST_GROUND;
                        on_ground <= 1'b1;
                    end else begin
                        pos_y <= y_fall[10:0];
                        vy    <= vy_fall;
                    end
                end
                default: begin
                    pos_y     <= Y_REST;
                    vy        <= '0;
                    state     <= ST_GROUND;
                    on_ground <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/draw_player.sv
// Player overlay stage: paints the player rectangle over the background
// stream with a fixed two-clock latency and exports the player position.
module draw_player
    import vga_pkg::*;
#(
    parameter int          PLAYER_W   = 32,
    parameter int          PLAYER_H   = 48,
    parameter int          X_INIT     = 100,
    parameter int          GROUND_Y   = 500,
    parameter int          SPEED_X    = 2,
    parameter int          JUMP_V0    = 12,
    parameter int          GRAVITY    = 1,
    parameter int          MAX_FALL   = 15,
    parameter logic [11:0] PLAYER_RGB = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        on_ground
);

    logic [10:0] s1_vcount, s1_hcount, s2_vcount, s2_hcount;
    logic        s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
    logic        s2_vsync, s2_vblnk, s2_hsync, s2_hblnk;
    logic [11:0] s1_rgb, s2_rgb;
    logic        s1_inside;
    logic        in_x, in_y;

    player_ctl #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H),
        .X_INIT   (X_INIT),
        .GROUND_Y (GROUND_Y),
        .SPEED_X  (SPEED_X),
        .JUMP_V0  (JUMP_V0),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vga_in.vblnk),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .on_ground (on_ground)
    );

    // rectangle bounds at 12 bits so pos + size cannot wrap
    assign in_x = ({1'b0, vga_in.hcount} >= {1'b0, pos_x}) &&
                  ({1'b0, vga_in.hcount} <= {1'b0, pos_x} + 12'(PLAYER_W - 1));
    assign in_y = ({1'b0, vga_in.vcount} >= {1'b0, pos_y}) &&
                  ({1'b0, vga_in.vcount} <= {1'b0, pos_y} + 12'(PLAYER_H - 1));

    // stage 1: register the incoming stream and the inside-rectangle result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vcount <= '0;
            s1_vsync  <= 1'b0;
            s1_vblnk  <= 1'b0;
            s1_hcount <= '0;
            s1_hsync  <= 1'b0;
            s1_hblnk  <= 1'b0;
            s1_rgb    <= '0;
            s1_inside <= 1'b0;
        end else begin
            s1_vcount <= vga_in.vcount;
            s1_vsync  <= vga_in.vsync;
            s1_vblnk  <= vga_in.vblnk;
            s1_hcount <= vga_in.hcount;
            s1_hsync  <= vga_in.hsync;
            s1_hblnk  <= vga_in.hblnk;
            s1_rgb    <= vga_in.rgb;
            s1_inside <= in_x && in_y;
        end
    end

    // stage 2: choose player colour outside blanking, else pass background
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vcount <= '0;
            s2_vsync  <= 1'b0;
            s2_vblnk  <= 1'b0;
            s2_hcount <= '0;
            s2_hsync  <= 1'b0;
            s2_hblnk  <= 1'b0;
            s2_rgb    <= '0;
        end else begin
            s2_vcount <= s1_vcount;
            s2_vsync  <= s1_vsync;
            s2_vblnk  <= s1_vblnk;
            s2_hcount <= s1_hcount;
            s2_hsync  <= s1_hsync;
            s2_hblnk  <= s1_hblnk;
            s2_rgb    <= (s1_inside && !s1_hblnk && !s1_vblnk) ? PLAYER_RGB : s1_rgb;
        end
    end

    assign vga_out.vcount = s2_vcount;
    assign vga_out.vsync  = s2_vsync;
    assign vga_out.vblnk  = s2_vblnk;
    assign vga_out.hcount = s2_hcount;
    assign vga_out.hsync  = s2_hsync;
    assign vga_out.hblnk  = s2_hblnk;
    assign vga_out.rgb    = s2_rgb;

endmodule

// File: tb/tb_draw_player.sv
// Bench for draw_player: short synthetic frames, stream scoreboard and
// position checks against hand-derived values.
module tb_draw_player;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [10:0] pos_x, pos_y;
    logic        on_ground;

    vga_if vin();
    vga_if vout();

    draw_player dut (
        .clk       (clk),
        .rst       (rst),
        .vga_in    (vin),
        .vga_out   (vout),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .on_ground (on_ground)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [37:0] sb_q[$];
    int          exp_x = 100;
    int          exp_y = 452;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] out_word();
        return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
    endfunction

    // one pixel: compare the output owed from two cycles ago, then drive and queue
    task automatic pix(input int hc, input int vc, input logic hs, input logic hb,
                       input logic vs, input logic vb, input logic [11:0] bg, input logic jmp);
        logic [11:0] e_rgb;
        @(negedge clk);
        if (sb_q.size() >= 2) check_eq("stream", 64'(out_word()), 64'(sb_q.pop_front()));
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hsync  = hs;
        vin.hblnk  = hb;
        vin.vsync  = vs;
        vin.vblnk  = vb;
        vin.rgb    = bg;
        btn_jump   = jmp;
        e_rgb = bg;
        if (!hb && !vb && hc >= exp_x && hc <= exp_x + 31 && vc >= exp_y && vc <= exp_y + 47)
            e_rgb = 12'hF00;
        sb_q.push_back({11'(vc), vs, vb, 11'(hc), hs, hb, e_rgb});
    endtask

    // short frame: 6 active pixels well right of the player, then 4 blanking
    // pixels; the first blanking pixel is the frame tick. jump_at picks the
    // pixel index carrying a one-cycle jump press (-1 for none).
    task automatic frame(input int jump_at);
        for (int i = 0; i < 6; i++)
            pix(900 + i, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)), jump_at == i);
        for (int i = 0; i < 4; i++)
            pix(0, 0, 1'b1, 1'b1, i < 2, 1'b1, 12'h000, jump_at == 6 + i);
    endtask

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.hblnk = 1'b0;
        vin.vsync = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        #23;
        check_eq("reset_vga", 64'(out_word()), 64'd0);
        check_eq("reset_x", 64'(pos_x), 64'd100);
        check_eq("reset_y", 64'(pos_y), 64'd452);
        check_eq("reset_ground", 64'(on_ground), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        repeat (3) frame(-1);
        check_eq("idle_x", 64'(pos_x), 64'd100);
        check_eq("idle_y", 64'(pos_y), 64'd452);
        check_eq("idle_ground", 64'(on_ground), 64'd1);

        // overlay corners and edges around the resting player at (100,452)
        pix(100, 452, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5, 1'b0);
        pix(132, 452, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5, 1'b0);
        pix(100, 451, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0);
        pix(131, 499, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0);
        pix(99, 460, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b0);
        pix(100, 452, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        pix(110, 500, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0);

        btn_right = 1'b1;
        repeat (3) frame(-1);
        btn_right = 1'b0;
        check_eq("right_3", 64'(pos_x), 64'd106);

        btn_left = 1'b1; btn_right = 1'b1;
        frame(-1);
        btn_left = 1'b0; btn_right = 1'b0;
        check_eq("both_held", 64'(pos_x), 64'd106);

        btn_left = 1'b1;
        repeat (53) frame(-1);
        check_eq("left_to_zero", 64'(pos_x), 64'd0);
        frame(-1);
        check_eq("left_clamp", 64'(pos_x), 64'd0);
        btn_left = 1'b0;

        btn_right = 1'b1;
        repeat (496) frame(-1);
        check_eq("right_to_max", 64'(pos_x), 64'd992);
        frame(-1);
        check_eq("right_clamp", 64'(pos_x), 64'd992);
        btn_right = 1'b0;

        btn_left = 1'b1;
        repeat (446) frame(-1);
        btn_left = 1'b0;
        check_eq("back_to_100", 64'(pos_x), 64'd100);

        // mid-frame jump press: start tick, 12 rising ticks, 12 falling ticks
        frame(2);
        check_eq("jump_start_ground", 64'(on_ground), 64'd0);
        check_eq("jump_start_y", 64'(pos_y), 64'd452);
        repeat (12) frame(-1);
        check_eq("apex_y", 64'(pos_y), 64'd374);
        check_eq("apex_state", 64'(dut.u_ctl.state), 64'(ST_FALL));
        frame(3);
        check_eq("fall_1_y", 64'(pos_y), 64'd375);
        repeat (11) frame(-1);
        check_eq("land_y", 64'(pos_y), 64'd452);
        check_eq("land_ground", 64'(on_ground), 64'd1);
        frame(-1);
        check_eq("apex_press_ignored", 64'(on_ground), 64'd1);
        check_eq("after_land_y", 64'(pos_y), 64'd452);

        // press on the tick cycle itself
        frame(6);
        check_eq("tick_jump_ground", 64'(on_ground), 64'd0);
        frame(-1);
        check_eq("tick_jump_rise1", 64'(pos_y), 64'd440);
        frame(-1);
        check_eq("tick_jump_rise2", 64'(pos_y), 64'd429);

        // asynchronous reset in the middle of the rise
        pix(900, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_eq("midjump_rst_vga", 64'(out_word()), 64'd0);
        check_eq("midjump_rst_x", 64'(pos_x), 64'd100);
        check_eq("midjump_rst_y", 64'(pos_y), 64'd452);
        check_eq("midjump_rst_ground", 64'(on_ground), 64'd1);
        check_eq("midjump_rst_vy", 64'(dut.u_ctl.vy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        repeat (2) frame(-1);
        check_eq("post_rst_y", 64'(pos_y), 64'd452);
        check_eq("post_rst_ground", 64'(on_ground), 64'd1);
        pix(115, 470, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0);
        pix(116, 471, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0);
        pix(900, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0);
        pix(901, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_player.md
# draw_player

Overlay stage directly downstream of the level background drawer on the VGA pipeline. It takes the background stream over `vga_if`, keeps a player rectangle's position and jump state, and updates them once per frame from button inputs. It paints the player over the background and forwards the stream to the next stage. It also exports the player position for later collision and scoring logic.

## Interface
- `PLAYER_W`, 32: player width in pixels.
- `PLAYER_H`, 48: player height in pixels.
- `X_INIT`, 100: x position after reset.
- `GROUND_Y`, 500: first ground line; the player's resting top is `GROUND_Y - PLAYER_H` (452).
- `SPEED_X`, 2: horizontal step in pixels per frame.
- `JUMP_V0`, 12: initial upward velocity in pixels per frame.
- `GRAVITY`, 1: velocity change per frame.
- `MAX_FALL`, 15: cap on downward velocity.
- `PLAYER_RGB`, 12'hF00: player colour.
- `clk`  in  1: pixel clock, the only clock.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `vga_in`  `vga_if.in`: background stream (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb).
- `vga_out`  `vga_if.out`: stream with the player painted in.
- `btn_left`, `btn_right`, `btn_jump`  in  1 each: level-sensitive controls, already synchronous to `clk`.
- `pos_x`  out  11: player left edge.
- `pos_y`  out  11: player top edge.
- `on_ground`  out  1: high when the FSM is in ST_GROUND.

## Operation
- **Frame tick:** one-cycle pulse on the rising edge of `vga_in.vblnk` (vblnk high, previous-cycle vblnk low). All position and velocity updates happen only on the tick. Positions therefore never change in the active area, so the frame does not tear.
- **Jump request:**
  - `jump_req` is set on any cycle where `btn_jump` is 1.
  - It is cleared on every tick.
  - If set and tick land on the same cycle, the request counts for that tick.
- **Horizontal update (on tick):**
  - left only: `x = max(x - SPEED_X, 0)`.
  - right only: `x = min(x + SPEED_X, HOR_PIXELS - PLAYER_W)`.
  - both or neither: no change.
- **Vertical FSM** (`vy` is 6-bit unsigned):
  - ST_GROUND: `y = GROUND_Y - PLAYER_H`, `vy = 0`. On a tick with `jump_req` set, load `vy = JUMP_V0` and go to ST_RISE. `y` does not change on that tick.
  - ST_RISE, on tick: `y = y - vy` and `vy = vy - GRAVITY`. If the new `vy` is 0, go to ST_FALL.
  - ST_FALL, on tick: `vy = min(vy + GRAVITY, MAX_FALL)` and `y = y + vy_new`. If `y + vy_new >= GROUND_Y - PLAYER_H`, set `y = GROUND_Y - PLAYER_H` and `vy = 0`, and go to ST_GROUND.
  - A jump request while airborne is discarded when the tick clears it.
- **Overlay:**
  - A pixel is inside the player when `pos_x <= hcount <= pos_x + PLAYER_W - 1` and `pos_y <= vcount <= pos_y + PLAYER_H - 1`.
  - Inside and not blanking: rgb = `PLAYER_RGB`.
  - Otherwise rgb passes through unchanged. Blanking black is preserved.
- **Arithmetic:** positions are 11-bit unsigned, and every clamp is evaluated before the subtraction so nothing wraps. Comparison bounds are computed at 12 bits.
- **Reset values:**
  - All `vga_out` fields 0, and both pipeline stages cleared.
  - `pos_x = X_INIT`, `pos_y = GROUND_Y - PLAYER_H`.
  - `vy = 0`, state ST_GROUND, `jump_req = 0`, `on_ground = 1`.
  - Reset mid-jump returns the player to the ground at once.

## Timing
- Stream latency is exactly 2 clocks. Every `vga_out` field equals the corresponding `vga_in` field delayed by 2, with rgb modified as above.
  - Stage 1 registers `vga_in` and the inside-rectangle compare.
  - Stage 2 registers the selected rgb and the delayed sync, blank and count fields.
- `pos_x`, `pos_y` and `on_ground` are registered and change on the cycle after the tick.
- A full jump with defaults lasts 24 ticks: 12 rising to apex y=374, then 12 falling back to 452.

## Structure
- `vga_pkg` gains `typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} player_state_t`. `HOR_PIXELS` and `VER_PIXELS` already come from `vga_pkg`.
- Sub-module `player_ctl` holds the tick detector, `jump_req`, the FSM and the position/velocity registers, and outputs `pos_x`, `pos_y` and `on_ground`.
- `draw_player` instantiates `player_ctl` and implements the 2-stage overlay pipeline.

## Test plan
- Reset, then 3 frames with no buttons -> `pos = (100,452)`, `on_ground = 1`, `vga_out` equals `vga_in` delayed by 2 with rgb unchanged everywhere.
- Hold `btn_right` for 3 ticks -> `pos_x = 106`. From `pos_x = 1`, hold `btn_left` for 1 tick -> `pos_x = 0`, no wrap. Hold both -> no change.
- Pulse `btn_jump` for 1 cycle mid-frame:
  - 12 ticks later -> `pos_y = 374`, state ST_FALL.
  - 24 ticks later -> `pos_y = 452`, `on_ground = 1`.
  - Pulse `btn_jump` again at apex -> ignored.
- Player at (100,452), active pixel at hcount 100, vcount 452 -> `vga_out.rgb = 12'hF00` 2 cycles later. hcount 132 or vcount 451 -> background rgb. Same coordinates during hblnk -> 0.
- `btn_jump` asserted in the same cycle as the vblnk rising edge -> jump starts on that tick.
- Assert `rst = 0` during ST_RISE -> `pos = (100,452)`, `vy = 0`, `vga_out` all 0 immediately, with no clock edge required.
